hex_display_scanner: RTL and testbench

- Time-multiplexed driver for NDIGITS common-anode seven-segment digits sharing one segment bus. It is the parametrised successor of the team's single-digit hex decoder.
- It scans one digit at a time at a prescaled rate and decodes hex nibbles to segments.
- It supports optional leading-zero blanking and per-digit decimal points.
- New values are committed only at frame boundaries, using a load/ack handshake, so the processor's register-view outputs never show a torn (half-old, half-new) frame.

---
 rtl/hex_display_scanner.sv | 125 ++++++++++++
 tb/tb_hex_display_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Multiplexed hex driver for NDIGITS common-anode seven-segment digits on one segment bus.
// New values are committed only at frame boundaries (or while the scan is idle), so a frame never shows a torn value.
module hex_display_scanner #(
  parameter int NDIGITS       = 4,
  parameter int DIV_WIDTH     = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [4*NDIGITS-1:0] Value,
  input  logic [NDIGITS-1:0]   DP,
  input  logic                 Load,
  input  logic                 En,
  input  logic                 Blank_lz,
  output logic                 Ack,
  output logic [NDIGITS-1:0]   Anode,
  output logic [6:0]           Seg,
  output logic                 Dp_out
);

  localparam int                 IW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0]      LAST   = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_OFF = {NDIGITS{AN_ACTIVE_LOW != 0}};

  // Table is written a..g left to right, i.e. segment a is the MSB of the literal.
  function automatic logic [6:0] decode_ag(input logic [3:0] n);
    case (n)
      4'h0: decode_ag = 7'b0000001;
      4'h1: decode_ag = 7'b1001111;
      4'h2: decode_ag = 7'b0010010;
      4'h3: decode_ag = 7'b0000110;
      4'h4: decode_ag = 7'b1001100;
      4'h5: decode_ag = 7'b0100100;
      4'h6: decode_ag = 7'b0100000;
      4'h7: decode_ag = 7'b0001111;
      4'h8: decode_ag = 7'b0000000;
      4'h9: decode_ag = 7'b0001100;
      4'hA: decode_ag = 7'b0001000;
      4'hB: decode_ag = 7'b1100000;
      4'hC: decode_ag = 7'b0110001;
      4'hD: decode_ag = 7'b1000010;
      4'hE: decode_ag = 7'b0110000;
      default: decode_ag = 7'b0111000;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]    presc;
  logic [IW-1:0]           idx;
  logic [NDIGITS-1:0][3:0] shadow, staged;
  logic [NDIGITS-1:0]      shadow_dp, staged_dp;
  logic                    pending;
  logic                    tick, frame, commit;
  logic [3:0]              nib;
  logic [6:0]              seg_ag, seg_dec;
  logic                    upper_zero, blank;
  logic [NDIGITS-1:0]      onehot;

  assign tick   = En & (&presc);
  assign frame  = tick & (idx == LAST);
  // Idle (En=0) counts as a boundary: nothing is on screen, so nothing can tear.
  assign commit = (pending | Load) & (~En | frame);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc <= '0;
      idx   <= '0;
    end else if (En) begin
      presc <= presc + 1'b1;
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      shadow    <= '0;
      shadow_dp <= '0;
      staged    <= '0;
      staged_dp <= '0;
      pending   <= 1'b0;
      Ack       <= 1'b0;
    end else begin
      Ack <= commit;
      if (commit) begin
        shadow    <= Load ? Value : staged;
        shadow_dp <= Load ? DP : staged_dp;
        pending   <= 1'b0;
      end else if (Load) begin
        staged    <= Value;
        staged_dp <= DP;
        pending   <= 1'b1;
      end
    end
  end

  always_comb begin
    nib    = shadow[idx];
    seg_ag = decode_ag(nib);
    seg_dec = '1;
    for (int b = 0; b < 7; b++) seg_dec[b] = seg_ag[6-b];
    upper_zero = 1'b1;
    for (int i = 0; i < NDIGITS; i++)
      if (i >= int'(idx) && shadow[i] != 4'h0) upper_zero = 1'b0;
    blank  = Blank_lz & (idx != '0) & upper_zero;
    onehot = '0;
    onehot[idx] = 1'b1;
  end

  // Anode, Seg and Dp_out share one register stage so they always switch together.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Anode  <= AN_OFF;
      Seg    <= 7'h7F;
      Dp_out <= 1'b1;
    end else if (!En) begin
      Anode  <= AN_OFF;
      Seg    <= 7'h7F;
      Dp_out <= 1'b1;
    end else begin
      Anode  <= onehot ^ AN_OFF;
      Seg    <= blank ? 7'h7F : seg_dec;
      Dp_out <= ~shadow_dp[idx];
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (NDIGITS=4, DIV_WIDTH=2, active-low anodes).
// Edge E_k is the k-th rising edge after reset release; values are sampled 1 time unit after it.
module tb_hex_display_scanner;

  logic        Clock, Resetn, Load, En, Blank_lz, Ack, Dp_out;
  logic [15:0] Value;
  logic [3:0]  DP, Anode;
  logic [6:0]  Seg;

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] an_e [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  hex_display_scanner #(.NDIGITS(4), .DIV_WIDTH(2), .AN_ACTIVE_LOW(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .Value(Value), .DP(DP), .Load(Load), .En(En),
    .Blank_lz(Blank_lz), .Ack(Ack), .Anode(Anode), .Seg(Seg), .Dp_out(Dp_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Segment strings are written a..g left to right; Seg carries a at bit 0.
  function automatic logic [6:0] ag(input logic [6:0] s);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = s[6-b];
    return r;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_dut();
    Load   = 1'b0;
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    int acks;
    En = 1'b1; Blank_lz = 1'b0;
    reset_dut();
    step();
    vectors++;
    if (Anode !== 4'b1110 || Seg !== ag(7'b0000001) || Dp_out !== 1'b1 || Ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_digit got an=%b seg=%b dp=%b ack=%b want an=1110 seg=%b dp=1 ack=0",
               Anode, Seg, Dp_out, Ack, ag(7'b0000001));
    end
    Value = 16'hFFFF; DP = 4'hF; Load = 1'b1;
    step();
    Load = 1'b0;
    for (int k = 3; k <= 5; k++) step();
    Resetn = 1'b0;
    #1;
    vectors++;
    if (Anode !== 4'b1111 || Seg !== 7'h7F || Dp_out !== 1'b1 || Ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_dark got an=%b seg=%b dp=%b ack=%b want an=1111 seg=1111111 dp=1 ack=0",
               Anode, Seg, Dp_out, Ack);
    end
    reset_dut();
    acks = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (Ack) acks++;
      if (k == 1 || k == 17) begin
        vectors++;
        if (Anode !== 4'b1110 || Seg !== ag(7'b0000001) || Dp_out !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_restart k=%0d got an=%b seg=%b dp=%b want an=1110 seg=%b dp=1",
                   k, Anode, Seg, Dp_out, ag(7'b0000001));
        end
      end
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL reset_discard_pending got acks=%0d want 0", acks);
    end
  endtask

  task automatic test_load_frame();
    logic [6:0] seg_e [4];
    logic       dp_e [4];
    int acks, ack_edge, d;
    seg_e = '{ag(7'b1100000), ag(7'b0001000), ag(7'b0010010), ag(7'b1001111)};
    dp_e  = '{1'b1, 1'b1, 1'b0, 1'b1};
    En = 1'b1; Blank_lz = 1'b0;
    reset_dut();
    step();
    Value = 16'h12AB; DP = 4'b0100; Load = 1'b1;
    step();
    Load = 1'b0;
    acks = Ack ? 1 : 0; ack_edge = Ack ? 2 : 0;
    for (int k = 3; k <= 32; k++) begin
      step();
      if (Ack) begin acks++; ack_edge = k; end
      if (k >= 17) begin
        d = (k - 17) / 4;
        vectors++;
        if (Anode !== an_e[d] || Seg !== seg_e[d] || Dp_out !== dp_e[d]) begin
          miscompares++;
          $display("FAIL load_frame k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   k, Anode, Seg, Dp_out, an_e[d], seg_e[d], dp_e[d]);
        end
      end
    end
    vectors++;
    if (acks !== 1 || ack_edge !== 16) begin
      miscompares++;
      $display("FAIL load_ack got count=%0d at edge %0d want count=1 at edge 16", acks, ack_edge);
    end
  endtask

  task automatic test_blank();
    logic [6:0] seg_a [4];
    logic [6:0] seg_b [4];
    int d;
    seg_a = '{ag(7'b0000001), ag(7'b0000110), 7'h7F, 7'h7F};
    seg_b = '{ag(7'b0000001), 7'h7F, 7'h7F, 7'h7F};
    En = 1'b1; Blank_lz = 1'b1;
    reset_dut();
    step();
    Value = 16'h0030; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    for (int k = 3; k <= 16; k++) step();
    for (int k = 17; k <= 32; k++) begin
      step();
      d = (k - 17) / 4;
      vectors++;
      if (Anode !== an_e[d] || Seg !== seg_a[d] || Dp_out !== 1'b1) begin
        miscompares++;
        $display("FAIL blank_0030 k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                 k, Anode, Seg, Dp_out, an_e[d], seg_a[d]);
      end
    end
    Value = 16'h0000; Load = 1'b1;
    step();
    Load = 1'b0;
    for (int k = 34; k <= 48; k++) step();
    for (int k = 49; k <= 64; k++) begin
      step();
      d = (k - 49) / 4;
      vectors++;
      if (Anode !== an_e[d] || Seg !== seg_b[d] || Dp_out !== 1'b1) begin
        miscompares++;
        $display("FAIL blank_0000 k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                 k, Anode, Seg, Dp_out, an_e[d], seg_b[d]);
      end
    end
    Blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks, ones;
    En = 1'b1; Blank_lz = 1'b0;
    reset_dut();
    step();
    Value = 16'h1111; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    acks = Ack ? 1 : 0;
    ones = 0;
    step(); if (Ack) acks++;
    step(); if (Ack) acks++;
    Value = 16'h2222; Load = 1'b1;
    step();
    Load = 1'b0;
    if (Ack) acks++;
    for (int k = 6; k <= 48; k++) begin
      step();
      if (Ack) acks++;
      if (Seg === ag(7'b1001111)) ones++;
      if (k >= 17) begin
        vectors++;
        if (Anode !== an_e[(k - 17) / 4 % 4] || Seg !== ag(7'b0010010)) begin
          miscompares++;
          $display("FAIL b2b_frame k=%0d got an=%b seg=%b want an=%b seg=%b",
                   k, Anode, Seg, an_e[(k - 17) / 4 % 4], ag(7'b0010010));
        end
      end
    end
    vectors++;
    if (acks !== 1 || ones !== 0) begin
      miscompares++;
      $display("FAIL b2b_ack got acks=%0d ones_seen=%0d want acks=1 ones_seen=0", acks, ones);
    end
  endtask

  task automatic test_coincident();
    logic [6:0] seg_e [4];
    int acks, threes, d;
    seg_e = '{ag(7'b0001111), ag(7'b0100000), ag(7'b0100100), ag(7'b1001100)};
    En = 1'b1; Blank_lz = 1'b0;
    reset_dut();
    for (int k = 1; k <= 4; k++) step();
    Value = 16'h3333; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    acks = Ack ? 1 : 0;
    threes = 0;
    for (int k = 6; k <= 15; k++) begin step(); if (Ack) acks++; end
    Value = 16'h4567; Load = 1'b1;
    step();
    Load = 1'b0;
    if (Ack) acks++;
    for (int k = 17; k <= 32; k++) begin
      step();
      if (Ack) acks++;
      if (Seg === ag(7'b0000110)) threes++;
      d = (k - 17) / 4;
      vectors++;
      if (Anode !== an_e[d] || Seg !== seg_e[d]) begin
        miscompares++;
        $display("FAIL coincident_frame k=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, Anode, Seg, an_e[d], seg_e[d]);
      end
    end
    vectors++;
    if (acks !== 1 || threes !== 0) begin
      miscompares++;
      $display("FAIL coincident_ack got acks=%0d threes_seen=%0d want acks=1 threes_seen=0", acks, threes);
    end
  endtask

  task automatic test_enable();
    En = 1'b1; Blank_lz = 1'b0;
    reset_dut();
    for (int k = 1; k <= 6; k++) step();
    En = 1'b0;
    step();
    vectors++;
    if (Anode !== 4'b1111 || Seg !== 7'h7F || Dp_out !== 1'b1 || Ack !== 1'b0) begin
      miscompares++;
      $display("FAIL en_off_dark got an=%b seg=%b dp=%b ack=%b want an=1111 seg=1111111 dp=1 ack=0",
               Anode, Seg, Dp_out, Ack);
    end
    Value = 16'h00FF; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    vectors++;
    if (Ack !== 1'b1 || Anode !== 4'b1111 || Seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL en_off_commit got ack=%b an=%b seg=%b want ack=1 an=1111 seg=1111111", Ack, Anode, Seg);
    end
    for (int k = 9; k <= 11; k++) begin
      step();
      vectors++;
      if (Ack !== 1'b0 || Anode !== 4'b1111 || Seg !== 7'h7F || Dp_out !== 1'b1) begin
        miscompares++;
        $display("FAIL en_off_hold k=%0d got ack=%b an=%b seg=%b dp=%b want ack=0 an=1111 seg=1111111 dp=1",
                 k, Ack, Anode, Seg, Dp_out);
      end
    end
    En = 1'b1;
    for (int k = 12; k <= 14; k++) begin
      step();
      vectors++;
      if (k < 14) begin
        if (Anode !== 4'b1101 || Seg !== ag(7'b0111000) || Ack !== 1'b0) begin
          miscompares++;
          $display("FAIL en_resume k=%0d got an=%b seg=%b ack=%b want an=1101 seg=%b ack=0",
                   k, Anode, Seg, Ack, ag(7'b0111000));
        end
      end else if (Anode !== 4'b1011 || Seg !== ag(7'b0000001)) begin
        miscompares++;
        $display("FAIL en_resume_next got an=%b seg=%b want an=1011 seg=%b", Anode, Seg, ag(7'b0000001));
      end
    end
  endtask

  initial begin
    Resetn = 1'b0; Load = 1'b0; En = 1'b1; Blank_lz = 1'b0;
    Value = '0; DP = '0;
    @(posedge Clock);
    #1;
    test_reset();
    test_load_frame();
    test_blank();
    test_back_to_back();
    test_coincident();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
